// File: rtl/clock_scaler_multi.sv
// clock_scaler_multi: per-channel programmable tick / 50% scaled_clk dividers with shadowed divisor writes.
// Optional CLOCK_SCALER_SYNC_EN adds a sync input that phase-aligns every channel.
module clock_scaler_multi #(
  parameter int CHANNELS = 2,
  parameter int CNT_W = 26,
  parameter int DEFAULT_DIV = 50_000_000,
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_wr,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic                cfg_ack,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] scaled_clk
`ifdef CLOCK_SCALER_SYNC_EN
  ,
  input  logic                sync
`endif
);
  logic do_sync, acc;
`ifdef CLOCK_SCALER_SYNC_EN
  assign do_sync = sync;
`else
  assign do_sync = 1'b0;
`endif
  assign acc = cfg_wr && 32'(cfg_sel) < CHANNELS;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cfg_ack <= 1'b0;
    else cfg_ack <= acc;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] count, div, pend_div;
    logic pend, tick_q, sclk_q, wr, run, wrap, apply;
    assign wr = acc && cfg_sel == SEL_W'(c);
    assign run = en[c] && div != '0;
    assign wrap = run && count == div - CNT_W'(1);
    // a pending divisor lands on a wrap, immediately when idle/stalled, or on sync
    assign apply = pend && (wrap || !run || do_sync);
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        count <= '0;
        div <= CNT_W'(DEFAULT_DIV);
        pend_div <= '0;
        pend <= 1'b0;
        tick_q <= 1'b0;
        sclk_q <= 1'b0;
      end else begin
        count <= (do_sync || wrap || (pend && !run)) ? '0 : run ? count + CNT_W'(1) : count;
        tick_q <= wrap && !do_sync;
        sclk_q <= !do_sync && (sclk_q ^ wrap);
        div <= apply ? pend_div : div;
        pend <= wr || (pend && !apply);
        pend_div <= wr ? cfg_div : pend_div;
      end
    assign tick[c] = tick_q;
    assign scaled_clk[c] = sclk_q;
  end
endmodule
